// File: rtl/adc7606c_pkg.sv
// Shared definitions for the AD7606C SPI link: frame layout, register map,
// responder FSM states and the CRC-8 used by both ends of the link.
package adc7606c_pkg;

  localparam logic [7:0] CRC8_POLY  = 8'h07;
  localparam int         FRAME_BITS = 32;

  localparam int RW_BIT   = 30;
  localparam int ADDR_MSB = 29;
  localparam int ADDR_LSB = 24;
  localparam int DATA_MSB = 23;
  localparam int DATA_LSB = 8;
  localparam int CRC_MSB  = 7;
  localparam int CRC_LSB  = 0;

  localparam logic [5:0] REG_CFG1 = 6'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } spi_state_t;

  // Bitwise MSB-first CRC-8 over the 24 header/data bits, init 0, no xorout.
  function automatic logic [7:0] crc8(input logic [23:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 23; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ CRC8_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/adc_sync.sv
// Multi-flop synchroniser for one asynchronous input; the reset value lets
// idle-high signals such as cs_n come out of reset in their inactive state.
module adc_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) sr <= {STAGES{RESET_VAL}};
    else       sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/adc7606c_spi_responder.sv
// Device-side SPI register responder and CONVST/BUSY emulator for the AD7606C
// link; read data requested in one frame is returned on miso in the next.
module adc7606c_spi_responder
  import adc7606c_pkg::*;
#(
  parameter int REG_COUNT   = 8,
  parameter int CONV_CYCLES = 200,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  input  logic        convst,
  output logic        busy,
  output logic        cfg_wr_valid,
  output logic [5:0]  cfg_wr_addr,
  output logic [15:0] cfg_wr_data,
  output logic        sample_valid,
  output logic        crc_error,
  output logic        frame_error,
  output logic        addr_error,
  output logic [1:0]  dbg_state
);

  localparam int         AW        = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int         CW        = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [6:0] REG_LIMIT = 7'(REG_COUNT);
  localparam logic [5:0] CNT_FULL  = 6'(FRAME_BITS);
  localparam logic [5:0] CNT_SAT   = 6'(FRAME_BITS + 1);

  logic cs_n_s, sclk_s, mosi_s, convst_s;
  logic sclk_prev, convst_prev;

  adc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d(cs_n), .q(cs_n_s));
  adc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(sclk), .q(sclk_s));
  adc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(mosi), .q(mosi_s));
  adc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_convst (
    .clk(clk), .reset(reset), .d(convst), .q(convst_s));

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_prev   <= 1'b0;
      convst_prev <= 1'b0;
    end else begin
      sclk_prev   <= sclk_s;
      convst_prev <= convst_s;
    end
  end

  logic sclk_rise, sclk_fall, convst_rise;
  assign sclk_rise   = sclk_s & ~sclk_prev;
  assign sclk_fall   = ~sclk_s & sclk_prev;
  assign convst_rise = convst_s & ~convst_prev;

  spi_state_t  state, state_nxt;
  logic [5:0]  bit_cnt;
  logic [31:0] rx_sr, tx_sr;
  logic [15:0] regs [REG_COUNT];

  logic        rx_rw;
  logic [5:0]  rx_addr;
  logic [15:0] rx_data;
  logic [7:0]  rx_crc;
  logic        frame_ok, crc_ok, addr_ok;
  logic [15:0] rd_data;
  logic [31:0] resp_word;
  logic        tx_load;
  logic [31:0] tx_load_val;

  assign rx_rw    = rx_sr[RW_BIT];
  assign rx_addr  = rx_sr[ADDR_MSB:ADDR_LSB];
  assign rx_data  = rx_sr[DATA_MSB:DATA_LSB];
  assign rx_crc   = rx_sr[CRC_MSB:CRC_LSB];
  assign frame_ok = (bit_cnt == CNT_FULL);
  assign crc_ok   = (crc8(rx_sr[FRAME_BITS-1:DATA_LSB]) == rx_crc);
  assign addr_ok  = ({1'b0, rx_addr} < REG_LIMIT);

  // Out-of-range addresses never index the array; they read back as zero.
  always_comb begin
    rd_data = '0;
    if (addr_ok) rd_data = regs[rx_addr[AW-1:0]];
  end

  assign resp_word = {2'b00, rx_addr, rd_data, crc8({2'b00, rx_addr, rd_data})};
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cfg_wr_valid = 1'b0;
    cfg_wr_addr  = '0;
    cfg_wr_data  = '0;
    crc_error    = 1'b0;
    frame_error  = 1'b0;
    addr_error   = 1'b0;
    tx_load      = 1'b0;
    tx_load_val  = '0;
    case (state)
      ST_IDLE:  if (!cs_n_s) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cs_n_s)  state_nxt = ST_CHECK;
      ST_CHECK: begin
        state_nxt = ST_IDLE;
        // Priority chain keeps every status pulse mutually exclusive.
        if (!frame_ok)     frame_error = 1'b1;
        else if (!crc_ok)  crc_error   = 1'b1;
        else begin
          if (!addr_ok) addr_error = 1'b1;
          if (rx_rw) begin
            tx_load     = 1'b1;
            tx_load_val = addr_ok ? resp_word : '0;
          end else if (addr_ok) begin
            cfg_wr_valid = 1'b1;
            cfg_wr_addr  = rx_addr;
            cfg_wr_data  = rx_data;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      miso    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          rx_sr   <= '0;
          // cs_n falling: present bit 31 immediately, before any sclk edge.
          if (!cs_n_s) begin
            miso  <= tx_sr[31];
            tx_sr <= {tx_sr[30:0], 1'b0};
          end else begin
            miso  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (cs_n_s) begin
            miso <= 1'b0;
          end else begin
            if (sclk_rise) begin
              if (bit_cnt < CNT_FULL) rx_sr <= {rx_sr[30:0], mosi_s};
              if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 6'd1;
            end
            if (sclk_fall) begin
              miso  <= tx_sr[31];
              tx_sr <= {tx_sr[30:0], 1'b0};
            end
          end
        end
        ST_CHECK: begin
          miso <= 1'b0;
          if (tx_load) tx_sr <= tx_load_val;
        end
        default: miso <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (cfg_wr_valid) begin
      regs[rx_addr[AW-1:0]] <= rx_data;
    end
  end

  // Conversion emulator runs independently of the SPI FSM.
  logic [CW-1:0] conv_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy         <= 1'b0;
      conv_cnt     <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (busy) begin
        if (conv_cnt == '0) begin
          busy         <= 1'b0;
          sample_valid <= 1'b1;
        end else begin
          conv_cnt <= conv_cnt - CW'(1);
        end
      end else if (convst_rise) begin
        busy     <= 1'b1;
        conv_cnt <= CW'(CONV_CYCLES - 1);
      end
    end
  end

endmodule

// File: tb/tb_adc7606c_spi_responder.sv
// Directed bench for the AD7606C SPI responder: frames are driven as a
// controller would, with a register/tx model producing the expected results.
module tb_adc7606c_spi_responder;
  import adc7606c_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_n = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        convst = 1'b0;
  logic        miso, busy, cfg_wr_valid, sample_valid;
  logic        crc_error, frame_error, addr_error;
  logic [5:0]  cfg_wr_addr;
  logic [15:0] cfg_wr_data;
  logic [1:0]  dbg_state;

  adc7606c_spi_responder #(
    .REG_COUNT(8), .CONV_CYCLES(200), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .miso(miso), .convst(convst), .busy(busy), .cfg_wr_valid(cfg_wr_valid),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .sample_valid(sample_valid), .crc_error(crc_error),
    .frame_error(frame_error), .addr_error(addr_error), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // monitor: observes pulses on the falling edge
  int          wr_cnt = 0, crc_cnt = 0, frm_cnt = 0, adr_cnt = 0;
  int          excl_bad = 0, busy_cyc = 0, sv_cnt = 0, sv_bad = 0;
  logic        busy_prev = 1'b0;
  logic [21:0] last_wr = '0;

  always @(negedge clk) begin
    if (cfg_wr_valid) begin
      wr_cnt  = wr_cnt + 1;
      last_wr = {cfg_wr_addr, cfg_wr_data};
    end
    if (crc_error)   crc_cnt = crc_cnt + 1;
    if (frame_error) frm_cnt = frm_cnt + 1;
    if (addr_error)  adr_cnt = adr_cnt + 1;
    if ((int'(cfg_wr_valid) + int'(crc_error) + int'(frame_error) + int'(addr_error)) > 1)
      excl_bad = excl_bad + 1;
    if (busy) busy_cyc = busy_cyc + 1;
    if (sample_valid) begin
      sv_cnt = sv_cnt + 1;
      if (busy || !busy_prev) sv_bad = sv_bad + 1;
    end
    busy_prev = busy;
  end

  // scoreboard state and model
  int          checks = 0;
  int          errors = 0;
  logic [21:0] exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] tx_model = '0;
  logic [15:0] model_reg [8];
  int          exp_wr = 0, exp_crc = 0, exp_frm = 0, exp_adr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Byte-at-a-time CRC-8 reference (poly 0x07, init 0).
  function automatic logic [7:0] crc_ref(input logic [23:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 2; k >= 0; k--) begin
      c = c ^ d[k*8 +: 8];
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] build_frame(input logic rw, input logic [5:0] addr,
                                              input logic [15:0] data);
    logic [31:0] w;
    w = {1'b0, rw, addr, data, 8'h00};
    w[7:0] = crc_ref(w[31:8]);
    return w;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_wr_cnt"},  32'(wr_cnt),  32'(exp_wr));
    check({tag, "_crc_cnt"}, 32'(crc_cnt), 32'(exp_crc));
    check({tag, "_frm_cnt"}, 32'(frm_cnt), 32'(exp_frm));
    check({tag, "_adr_cnt"}, 32'(adr_cnt), 32'(exp_adr));
  endtask

  // driver: one SPI frame of nbits clocks, mode 0, miso sampled before each rise
  task automatic do_frame(input string tag, input logic [31:0] w, input int nbits,
                          output logic [31:0] rx);
    logic [5:0]  a;
    logic [15:0] d;
    logic [21:0] e;
    rx = '0;
    rd_q.push_back(tx_model);
    cs_n = 1'b0;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 32) ? w[31-i] : 1'b0;
      tick(4);
      if (i < 32) rx[31-i] = miso;
      sclk = 1'b1;
      tick(8);
      sclk = 1'b0;
      tick(4);
    end
    tick(4);
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(8);
    check({tag, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
    for (int k = 0; k <= nbits; k++) tx_model = tx_model << 1;
    a = w[29:24];
    d = w[23:8];
    if (nbits == 32) begin
      check({tag, "_miso"}, rx, rd_q.pop_front());
      if (crc_ref(w[31:8]) != w[7:0]) begin
        exp_crc = exp_crc + 1;
      end else if (a >= 6'd8) begin
        exp_adr = exp_adr + 1;
        if (w[30]) tx_model = '0;
      end else if (w[30]) begin
        tx_model = {2'b00, a, model_reg[a[2:0]], crc_ref({2'b00, a, model_reg[a[2:0]]})};
      end else begin
        model_reg[a[2:0]] = d;
        exp_q.push_back({a, d});
        exp_wr = exp_wr + 1;
      end
    end else begin
      exp_frm = exp_frm + 1;
      void'(rd_q.pop_front());
    end
    check_counts(tag);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_wr_payload"}, {10'b0, last_wr}, {10'b0, e});
    end
  endtask

  // directed sequence
  initial begin
    logic [31:0] rx;
    int          b0, s0;
    logic [5:0]  ra;
    for (int i = 0; i < 8; i++) model_reg[i] = '0;

    tick(5);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_wr_valid", 32'(cfg_wr_valid), 32'd0);
    check("rst_errs", {29'b0, crc_error, frame_error, addr_error}, 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    tick(4);

    do_frame("wr_a0", 32'h0100A002, 32, rx);
    do_frame("wr_badcrc", 32'h0100A003, 32, rx);
    do_frame("rd_cmd", 32'h410000ED, 32, rx);
    do_frame("rd_data", 32'h410000ED, 32, rx);
    check("rd_literal", rx, 32'h0100A002);

    do_frame("short20", build_frame(1'b0, 6'd2, 16'h1234), 20, rx);
    do_frame("wr_after_short", build_frame(1'b0, 6'd2, 16'h1234), 32, rx);
    do_frame("idle_cs", 32'h0, 0, rx);
    do_frame("wr_bad_addr", build_frame(1'b0, 6'd10, 16'hFFFF), 32, rx);
    do_frame("rd_a2", build_frame(1'b1, 6'd2, 16'h0), 32, rx);
    do_frame("rd_bad_addr", build_frame(1'b1, 6'd10, 16'h0), 32, rx);
    do_frame("long34", build_frame(1'b0, 6'd3, 16'h5555), 34, rx);
    do_frame("wr_top", build_frame(1'b0, 6'd7, 16'hFFFF), 32, rx);

    for (int n = 0; n < 6; n++) begin
      ra = 6'($urandom_range(0, 9));
      do_frame("rand", build_frame(1'($urandom_range(0, 1)), ra,
               16'($urandom_range(0, 65535))), 32, rx);
    end
    do_frame("flush", build_frame(1'b1, 6'd7, 16'h0), 32, rx);
    do_frame("flush2", build_frame(1'b1, 6'd0, 16'h0), 32, rx);

    // conversion: second convst 50 cycles in must be ignored
    b0 = busy_cyc;
    s0 = sv_cnt;
    convst = 1'b1;
    tick(3);
    convst = 1'b0;
    tick(47);
    check("conv_busy_mid", 32'(busy), 32'd1);
    convst = 1'b1;
    tick(3);
    convst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (sv_cnt != s0) break;
      tick(1);
    end
    tick(300);
    check("conv_busy_cycles", 32'(busy_cyc - b0), 32'd200);
    check("conv_sample_cnt", 32'(sv_cnt - s0), 32'd1);
    check("conv_sv_on_fall", 32'(sv_bad), 32'd0);
    check("conv_busy_end", 32'(busy), 32'd0);

    // reset at bit 16 of a write while a conversion is running
    convst = 1'b1;
    tick(3);
    convst = 1'b0;
    tick(10);
    check("pre_rst_busy", 32'(busy), 32'd1);
    cs_n = 1'b0;
    tick(8);
    rx = build_frame(1'b0, REG_CFG1, 16'hBEEF);
    for (int i = 0; i < 16; i++) begin
      mosi = rx[31-i];
      tick(4);
      sclk = 1'b1;
      tick(8);
      sclk = 1'b0;
      tick(4);
    end
    reset = 1'b1;
    tick(1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_miso", 32'(miso), 32'd0);
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) model_reg[i] = '0;
    tx_model = '0;
    check_counts("midrst");
    check("midrst_busy_after", 32'(busy), 32'd0);
    do_frame("rd_cfg1_cmd", build_frame(1'b1, REG_CFG1, 16'h0), 32, rx);
    do_frame("rd_cfg1_data", build_frame(1'b1, 6'd0, 16'h0), 32, rx);
    check("cfg1_cleared", rx, {2'b00, REG_CFG1, 16'h0000, crc_ref({2'b00, REG_CFG1, 16'h0000})});

    check("exclusive_pulses", 32'(excl_bad), 32'd0);
    tick(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
